// File: rtl/hdmi_tx_pkg.sv
// hdmi_tx_pkg: TMDS code constants, FSM states, pixel record and helpers shared by the HDMI framer.
package hdmi_tx_pkg;
  localparam int TMDS_W = 10;
  localparam logic [TMDS_W-1:0] CTL_00 = 10'b1101010100;
  localparam logic [TMDS_W-1:0] CTL_01 = 10'b0010101011;
  localparam logic [TMDS_W-1:0] CTL_10 = 10'b0101010100;
  localparam logic [TMDS_W-1:0] CTL_11 = 10'b1010101011;
  localparam logic [TMDS_W-1:0] GUARD_02 = 10'b1011001100;
  localparam logic [TMDS_W-1:0] GUARD_1 = 10'b0100110011;
  localparam logic [TMDS_W-1:0] CLK_PAT = 10'b0000011111;
  localparam logic [1:0] ST_CTRL = 2'd0;
  localparam logic [1:0] ST_PRE = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;
  localparam logic [1:0] ST_VIDEO = 2'd3;
  typedef struct packed {
    logic [23:0] rgb;
    logic hs;
    logic vs;
    logic de;
  } pix_t;
  function automatic logic [TMDS_W-1:0] ctl_code(input logic [1:0] c);
    return c == 2'b00 ? CTL_00 : c == 2'b01 ? CTL_01 : c == 2'b10 ? CTL_10 : CTL_11;
  endfunction
  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n += 4'(d[i]);
    return n;
  endfunction
endpackage

// File: rtl/hdmi_tmds_chan.sv
// hdmi_tmds_chan: one TMDS data channel -- 8b/10b video encode with running disparity and symbol mux.
import hdmi_tx_pkg::*;
module hdmi_tmds_chan (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        sel,
  input  logic [1:0]        ctl,
  input  logic [TMDS_W-1:0] guard,
  input  logic [7:0]        data,
  output logic [TMDS_W-1:0] sym
);
  logic xnor_m;
  logic [8:0] qm;
  logic [3:0] n1, n1q;
  logic signed [4:0] disp, disp_n, bal;
  logic [TMDS_W-1:0] vid;
  always_comb begin
    n1 = ones8(data);
    xnor_m = n1 > 4'd4 || (n1 == 4'd4 && !data[0]);
    // qm[i] is the parity of data[i:0], inverted on odd stages of the XNOR chain
    for (int i = 0; i < 8; i++) qm[i] = ^(data & (8'hFF >> (7 - i))) ^ (xnor_m && i % 2 == 1);
    qm[8] = ~xnor_m;
    n1q = ones8(qm[7:0]);
    bal = $signed({n1q, 1'b0}) - 5'sd8;
    if (disp == 5'sd0 || bal == 5'sd0) begin
      vid = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      disp_n = qm[8] ? disp + bal : disp - bal;
    end else if ((disp > 5'sd0) == (bal > 5'sd0)) begin
      vid = {1'b1, qm[8], ~qm[7:0]};
      disp_n = disp + (qm[8] ? 5'sd2 : 5'sd0) - bal;
    end else begin
      vid = {1'b0, qm[8], qm[7:0]};
      disp_n = disp - (qm[8] ? 5'sd0 : 5'sd2) + bal;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sym <= CTL_00;
      disp <= 5'sd0;
    end else begin
      sym <= sel == ST_VIDEO ? vid : sel == ST_GUARD ? guard : ctl_code(ctl);
      disp <= sel == ST_VIDEO ? disp_n : 5'sd0;
    end
endmodule

// File: rtl/hdmi_tx_framer.sv
// hdmi_tx_framer: HDMI/DVI link framer -- delays pixels by the preamble+guard lead so the live de
// can announce each line, inserts preamble and guard band, and drives three TMDS channels.
import hdmi_tx_pkg::*;
module hdmi_tx_framer #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN = 2,
  parameter int HDMI_MODE = 1
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic              display_en,
  input  logic [23:0]       rgb,
  input  logic              hs,
  input  logic              vs,
  input  logic              de,
  output logic [TMDS_W-1:0] sym_0,
  output logic [TMDS_W-1:0] sym_1,
  output logic [TMDS_W-1:0] sym_2,
  output logic [TMDS_W-1:0] sym_clk,
  output logic              gap_err
);
  localparam int LEAD = PREAMBLE_LEN + GUARD_LEN;
  pix_t dly [LEAD];
  pix_t dd;
  logic [4:0] low_run;
  logic [3:0] cnt;
  logic [1:0] st, cur;
  logic rise, live;
  assign dd = dly[LEAD-1];
  assign rise = de && !dly[0].de;
  assign live = HDMI_MODE != 0 && display_en && rise;
  assign sym_clk = CLK_PAT;
  // cur is the state of the symbol being built this cycle; st remembers it for counting
  always_comb begin
    cur = st == ST_PRE ? (cnt < 4'(PREAMBLE_LEN) ? ST_PRE : GUARD_LEN > 0 ? ST_GUARD : ST_VIDEO)
        : st == ST_GUARD ? (cnt < 4'(GUARD_LEN) ? ST_GUARD : ST_VIDEO)
        : dd.de ? ST_VIDEO : ST_CTRL;
    cur = !display_en ? ST_CTRL : (live && low_run >= 5'(LEAD)) ? ST_PRE : cur;
  end
  always_ff @(posedge pixel_clk or posedge rst)
    if (rst) begin
      st <= ST_CTRL;
      cnt <= '0;
      low_run <= '0;
      gap_err <= 1'b0;
      for (int i = 0; i < LEAD; i++) dly[i] <= '0;
    end else begin
      st <= cur;
      cnt <= cur != st ? 4'd1 : cnt + 4'd1;
      low_run <= de ? 5'd0 : low_run == 5'(LEAD) ? low_run : low_run + 5'd1;
      if (live && low_run < 5'(LEAD)) gap_err <= 1'b1;
      dly[0] <= {rgb, hs, vs, de};
      for (int i = 1; i < LEAD; i++) dly[i] <= dly[i-1];
    end
  hdmi_tmds_chan u_ch0 (
    .clk(pixel_clk), .rst(rst), .sel(cur), .ctl(display_en ? {dd.vs, dd.hs} : 2'b00),
    .guard(GUARD_02), .data(dd.rgb[7:0]), .sym(sym_0)
  );
  hdmi_tmds_chan u_ch1 (
    .clk(pixel_clk), .rst(rst), .sel(cur), .ctl(cur == ST_PRE ? 2'b01 : 2'b00),
    .guard(GUARD_1), .data(dd.rgb[15:8]), .sym(sym_1)
  );
  hdmi_tmds_chan u_ch2 (
    .clk(pixel_clk), .rst(rst), .sel(cur), .ctl(2'b00),
    .guard(GUARD_02), .data(dd.rgb[23:16]), .sym(sym_2)
  );
endmodule
